count_event_monitor: RTL and testbench
======================================

Name: count_event_monitor

Overview:
Downstream consumer of the 4-bit counter's q_out. Samples the count every clock and classifies transitions into events: wrap (F->0), restart (non-wrap return to 0), and threshold match. It keeps an extended wrap count and queues event records in a small FIFO. Records leave through a valid/ready handshake toward a logger or host-side reader.

Parameters:
WRAP_W, 8, width of the extended wrap counter; wraps modulo 2^WRAP_W.
DEPTH, 4, event FIFO depth; power of two, at least 2.
EVT_W, 2+4+WRAP_W (derived, localparam), event record width.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
q_in  in  4  counter value (the counter's q_out).
threshold  in  4  match value, sampled live every cycle.
clear  in  1  synchronous soft clear.
evt_ready  in  1  consumer accepts the head record.
evt_valid  out  1  FIFO non-empty; head record presented.
evt_data  out  EVT_W  head record {type[1:0], q[3:0], wrap_cnt[WRAP_W-1:0]}.
wrap_cnt  out  WRAP_W  running wrap count.
evt_drop  out  1  sticky flag: an event was lost because the FIFO was full.

Behaviour:
- Reset (async, active-high):
  - q_prev=0, wrap_cnt=0, FIFO empty.
  - evt_valid=0, evt_data=0, evt_drop=0.
- Per-cycle classification on (q_prev, q_in); q_prev<=q_in every cycle:
  - WRAP: q_prev==4'hF and q_in==4'h0.
  - RESTART: q_in==0, q_prev!=0, q_prev!=F (the upstream counter was reset).
  - MATCH: q_in!=q_prev and q_in==threshold.
  - A held value generates nothing, so there is no repeated MATCH.
- At most one event per cycle. Priority is WRAP > RESTART > MATCH; threshold==0 coinciding with a wrap or restart yields only that event.
- Type codes: NONE=0, WRAP=1, MATCH=2, RESTART=3.
- wrap_cnt increments on WRAP and rolls over at 2^WRAP_W. The record carries the post-increment wrap_cnt and the current q_in.
- Latency: the event is detected at edge N and written into the FIFO at edge N. evt_valid is high in cycle N+1 (show-ahead head).
- Handshake:
  - Pop occurs when evt_valid && evt_ready.
  - evt_data must stay stable while evt_valid=1 and evt_ready=0.
  - evt_valid does not depend combinationally on evt_ready.
- Push rules:
  - A push occurs when there is an event and the FIFO is not full.
  - When full and a pop happens in the same cycle, the push is accepted and the count stays at DEPTH.
  - When full and no pop happens, the event is discarded, evt_drop<=1 (sticky), and wrap_cnt still increments.
- Empty FIFO with an event and evt_ready=1 in the same cycle: no bypass. The record appears next cycle.
- clear has priority over all of the following in its cycle:
  - FIFO emptied, wrap_cnt=0, evt_drop=0.
  - q_prev<=q_in.
  - Any event or pop in that cycle is ignored.
- Reset mid-operation discards queued records with no partial handshake. After reset, the first cycle compares against q_prev=0.

Decomposition:
- Package count_mon_pkg:
  - evt_type_e enum (2-bit: EVT_NONE, EVT_WRAP, EVT_MATCH, EVT_RESTART).
  - Packed struct evt_rec_t {type, q, wrap_cnt}, parameterised by WRAP_W through the package localparam default.
  - Localparam CNT_MAX=4'hF.
- Sub-module count_evt_fifo: synchronous show-ahead FIFO (DEPTH, EVT_W) with push/pop/full/empty and sync flush. Async-reset pointers and count.
- The top holds the classifier, wrap counter and drop flag.

Test Plan:
- Reset asserted with q_in=9 -> evt_valid=0, wrap_cnt=0, evt_drop=0; after release, first cycle with q_in=9 -> no event (non-zero, not threshold when threshold=3).
- threshold=5, evt_ready=1, q_in ramps 0..F then 0 -> exactly two records: {MATCH,5,0}, then {WRAP,0,1}; wrap_cnt=1.
- q_in 7 -> 0 -> one record {RESTART,0,0}; wrap_cnt unchanged; threshold=0 on the same step still yields only RESTART.
- evt_ready=0, DEPTH=4, five F->0 wraps -> four records wrap_cnt 1..4 held stable, evt_drop=1, wrap_cnt output=5; then ready=1 drains 4 records in 4 cycles.
- FIFO full, pop and wrap in the same cycle -> new record accepted, evt_drop stays 0, evt_valid stays 1.
- clear in the same cycle as F->0 with 2 queued records -> evt_valid=0 next cycle, wrap_cnt=0, no WRAP record; async reset pulse mid-drain -> all outputs 0 immediately.

Source files
------------

// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared event types and record layout for the count event monitor
package count_mon_pkg;

  localparam logic [3:0] CNT_MAX    = 4'hF;
  localparam int         WRAP_W_DEF = 8;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'd0,
    EVT_WRAP    = 2'd1,
    EVT_MATCH   = 2'd2,
    EVT_RESTART = 2'd3
  } evt_type_e;

  typedef struct packed {
    evt_type_e             typ;
    logic [3:0]            q;
    logic [WRAP_W_DEF-1:0] wrap_cnt;
  } evt_rec_t;

endpackage

// File: rtl/count_evt_fifo.sv
// rtl/count_evt_fifo.sv - show-ahead event record FIFO with synchronous flush
module count_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  // Head is masked while empty so the output reads zero out of reset and after flush.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/count_event_monitor.sv
// rtl/count_event_monitor.sv - classifies counter transitions and queues event records
module count_event_monitor
  import count_mon_pkg::*;
#(
  parameter  int WRAP_W = 8,
  parameter  int DEPTH  = 4,
  localparam int EVT_W  = 2 + 4 + WRAP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        q_in,
  input  logic [3:0]        threshold,
  input  logic              clear,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [EVT_W-1:0]  evt_data,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              evt_drop
);

  logic [3:0]        q_prev_q;
  logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
  logic              drop_q, drop_d;
  evt_type_e         evt_type;
  logic              evt_hit, push, pop, fifo_full, fifo_empty;
  logic [EVT_W-1:0]  rec;

  always_comb begin
    evt_type = EVT_NONE;
    if (q_prev_q == CNT_MAX && q_in == 4'h0)
      evt_type = EVT_WRAP;
    else if (q_in == 4'h0 && q_prev_q != 4'h0)
      evt_type = EVT_RESTART;
    else if (q_in != q_prev_q && q_in == threshold)
      evt_type = EVT_MATCH;
  end

  assign evt_hit   = (evt_type != EVT_NONE);
  assign evt_valid = !fifo_empty;
  assign pop       = evt_valid && evt_ready && !clear;
  // A full FIFO still takes the new record when the head leaves in the same cycle.
  assign push      = evt_hit && (!fifo_full || pop) && !clear;

  always_comb begin
    wrap_cnt_d = wrap_cnt_q;
    drop_d     = drop_q;
    if (clear) begin
      wrap_cnt_d = '0;
      drop_d     = 1'b0;
    end else begin
      if (evt_type == EVT_WRAP)
        wrap_cnt_d = wrap_cnt_q + {{(WRAP_W-1){1'b0}}, 1'b1};
      if (evt_hit && fifo_full && !pop)
        drop_d = 1'b1;
    end
  end

  assign rec = {evt_type, q_in, wrap_cnt_d};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_prev_q   <= 4'h0;
      wrap_cnt_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      q_prev_q   <= q_in;
      wrap_cnt_q <= wrap_cnt_d;
      drop_q     <= drop_d;
    end
  end

  assign wrap_cnt = wrap_cnt_q;
  assign evt_drop = drop_q;

  count_evt_fifo #(
    .DEPTH(DEPTH),
    .W    (EVT_W)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .flush_i(clear),
    .push_i (push),
    .wdata_i(rec),
    .pop_i  (pop),
    .rdata_o(evt_data),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

endmodule

// File: tb/tb_count_event_monitor.sv
// tb/tb_count_event_monitor.sv - scoreboard bench for count_event_monitor
module tb_count_event_monitor;

  localparam int WRAP_W = 8;
  localparam int DEPTH  = 4;
  localparam int EVT_W  = 2 + 4 + WRAP_W;

  logic              clk = 1'b0;
  logic              reset;
  logic [3:0]        q_in;
  logic [3:0]        threshold;
  logic              clear;
  logic              evt_ready;
  logic              evt_valid;
  logic [EVT_W-1:0]  evt_data;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              evt_drop;

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;

  logic [EVT_W-1:0]  exp_q[$];
  logic [3:0]        m_prev;
  logic [WRAP_W-1:0] m_wrap;
  logic              m_drop;

  always #5 clk = ~clk;

  count_event_monitor #(.WRAP_W(WRAP_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .q_in     (q_in),
    .threshold(threshold),
    .clear    (clear),
    .evt_ready(evt_ready),
    .evt_valid(evt_valid),
    .evt_data (evt_data),
    .wrap_cnt (wrap_cnt),
    .evt_drop (evt_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_evt(input logic [3:0] p, input logic [3:0] c, input logic [3:0] t);
    if (p == 4'hF && c == 4'h0) return 2'd1;
    if (c == 4'h0 && p != 4'h0) return 2'd3;
    if (c != p && c == t)       return 2'd2;
    return 2'd0;
  endfunction

  // Called just after a falling edge; drives one cycle and updates the model.
  task automatic step(input logic [3:0] q, input logic [3:0] thr, input logic rdy, input logic clr);
    logic [1:0] ev;
    logic       full, do_pop;
    q_in = q; threshold = thr; evt_ready = rdy; clear = clr;
    #1;
    chk("valid", {31'd0, evt_valid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("head", {18'd0, evt_data}, {18'd0, exp_q[0]});
    ev   = ref_evt(m_prev, q, thr);
    full = (exp_q.size() == DEPTH);
    if (clr) begin
      exp_q.delete();
      m_wrap = '0;
      m_drop = 1'b0;
    end else begin
      do_pop = (exp_q.size() != 0) && rdy;
      if (do_pop) begin
        void'(exp_q.pop_front());
        n_pops++;
      end
      if (ev != 2'd0) begin
        if (ev == 2'd1) m_wrap = m_wrap + 8'd1;
        if (!full || do_pop) exp_q.push_back({ev, q, m_wrap});
        else m_drop = 1'b1;
      end
    end
    m_prev = q;
    @(posedge clk);
    @(negedge clk);
    chk("wrap_cnt", {24'd0, wrap_cnt}, {24'd0, m_wrap});
    chk("drop", {31'd0, evt_drop}, {31'd0, m_drop});
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_prev = 4'h0;
    m_wrap = '0;
    m_drop = 1'b0;
  endtask

  initial begin
    reset = 1'b1; q_in = 4'h9; threshold = 4'h3; clear = 1'b0; evt_ready = 1'b1;
    model_reset();
    @(negedge clk);
    #1;
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_data", {18'd0, evt_data}, 32'd0);
    chk("rst_wrap", {24'd0, wrap_cnt}, 32'd0);
    chk("rst_drop", {31'd0, evt_drop}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(4'h9, 4'h3, 1'b1, 1'b0);
    chk("no_evt_after_rst", {31'd0, evt_valid}, 32'd0);

    // Ramp 0..F then 0 with threshold 5.
    step(4'h0, 4'h5, 1'b1, 1'b1);
    n_pops = 0;
    for (int i = 0; i < 16; i++) step(4'(i), 4'h5, 1'b1, 1'b0);
    step(4'h0, 4'h5, 1'b1, 1'b0);
    step(4'h0, 4'h5, 1'b1, 1'b0);
    step(4'h0, 4'h5, 1'b1, 1'b0);
    chk("ramp_records", n_pops, 32'd2);
    chk("ramp_wrap", {24'd0, wrap_cnt}, 32'd1);

    // Restart with threshold 0 on the same step.
    step(4'h7, 4'h0, 1'b0, 1'b0);
    step(4'h0, 4'h0, 1'b0, 1'b0);
    chk("restart_rec", {18'd0, evt_data}, {18'd0, 2'd3, 4'h0, 8'd1});
    step(4'h0, 4'h0, 1'b1, 1'b0);
    step(4'h0, 4'h0, 1'b1, 1'b0);

    // Five wraps with no consumer: four kept, one dropped.
    step(4'h0, 4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 4'h5, 1'b0, 1'b0);
      step(4'h0, 4'h5, 1'b0, 1'b0);
    end
    chk("ovf_drop", {31'd0, evt_drop}, 32'd1);
    chk("ovf_wrap", {24'd0, wrap_cnt}, 32'd5);
    chk("ovf_head", {18'd0, evt_data}, {18'd0, 2'd1, 4'h0, 8'd1});
    for (int i = 0; i < 4; i++) step(4'h0, 4'h5, 1'b1, 1'b0);
    chk("drained", {31'd0, evt_valid}, 32'd0);

    // Full FIFO: pop and wrap coincide.
    step(4'h0, 4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'hF, 4'h5, 1'b0, 1'b0);
      step(4'h0, 4'h5, 1'b0, 1'b0);
    end
    step(4'hF, 4'h5, 1'b0, 1'b0);
    step(4'h0, 4'h5, 1'b1, 1'b0);
    chk("full_pop_drop", {31'd0, evt_drop}, 32'd0);
    chk("full_pop_valid", {31'd0, evt_valid}, 32'd1);
    chk("full_pop_head", {18'd0, evt_data}, {18'd0, 2'd1, 4'h0, 8'd2});
    for (int i = 0; i < 5; i++) step(4'h0, 4'h5, 1'b1, 1'b0);

    // Clear coinciding with a wrap while two records are queued.
    step(4'h0, 4'h5, 1'b0, 1'b1);
    step(4'hF, 4'h5, 1'b0, 1'b0);
    step(4'h0, 4'h5, 1'b0, 1'b0);
    step(4'hF, 4'h5, 1'b0, 1'b0);
    step(4'h0, 4'h5, 1'b0, 1'b0);
    step(4'hF, 4'h5, 1'b0, 1'b0);
    step(4'h0, 4'h5, 1'b1, 1'b1);
    chk("clr_valid", {31'd0, evt_valid}, 32'd0);
    chk("clr_wrap", {24'd0, wrap_cnt}, 32'd0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 3; i++) begin
      step(4'hF, 4'h5, 1'b0, 1'b0);
      step(4'h0, 4'h5, 1'b0, 1'b0);
    end
    step(4'h0, 4'h5, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {31'd0, evt_valid}, 32'd0);
    chk("arst_data", {18'd0, evt_data}, 32'd0);
    chk("arst_wrap", {24'd0, wrap_cnt}, 32'd0);
    chk("arst_drop", {31'd0, evt_drop}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(4'h0, 4'h5, 1'b1, 1'b0);
    step(4'h5, 4'h5, 1'b1, 1'b0);
    step(4'h5, 4'h5, 1'b1, 1'b0);
    step(4'h5, 4'h5, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
